// File: rtl/yapp_router_nch_if.sv
// ---------------------------------------------------------------------------
// yapp_router_nch_if
// Bundle of all non-clock/reset signals of yapp_router_nch.
//   YAPP input : in_data, in_data_vld (to router), in_suspend (from router)
//   Channels   : data_ch[NUM_CH*8], data_vld_ch[NUM_CH] (from router),
//                suspend_ch[NUM_CH] (to router)
//   HBUS       : haddr, hwdata, hen, hwr_rd (to router), hrdata (from router)
//   Status     : error (from router)
// Modports: master = traffic/HBUS source side, slave = router side.
// ---------------------------------------------------------------------------
interface yapp_router_nch_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0]        in_data;
  logic                     in_data_vld;
  logic                     in_suspend;
  logic [NUM_CH*DATA_W-1:0] data_ch;
  logic [NUM_CH-1:0]        data_vld_ch;
  logic [NUM_CH-1:0]        suspend_ch;
  logic [15:0]              haddr;
  logic [7:0]               hwdata;
  logic [7:0]               hrdata;
  logic                     hen;
  logic                     hwr_rd;
  logic                     error;

  modport master (
    output in_data, in_data_vld, suspend_ch, haddr, hwdata, hen, hwr_rd,
    input  in_suspend, data_ch, data_vld_ch, hrdata, error
  );

  modport slave (
    input  in_data, in_data_vld, suspend_ch, haddr, hwdata, hen, hwr_rd,
    output in_suspend, data_ch, data_vld_ch, hrdata, error
  );
endinterface

// File: rtl/yapp_router_nch.sv
// ---------------------------------------------------------------------------
// yapp_router_nch
// Validates YAPP packets arriving on one byte stream, routes each accepted
// packet into one of NUM_CH channel FIFOs and drains every FIFO onto its own
// output channel under that channel's suspend. An HBUS register file holds
// control (router_en, ch_en, max_len) and status (error counters, FIFO empty).
// Ports:
//   clock  - rising-edge clock for all logic
//   reset  - synchronous, active-high
//   bus    - yapp_router_nch_if.slave (YAPP input, channel outputs, HBUS, error)
// Optional build macro: YAPP_ROUTER_STATS_EN adds per-channel packet counters
// readable at 0x1010+i; without it those addresses are unmapped.
// ---------------------------------------------------------------------------
module yapp_router_nch #(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  yapp_router_nch_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_PARITY, S_DROP} state_t;

  state_t            state_q;
  logic [5:0]        len_cnt_q;
  logic [1:0]        cur_ch_q;
  logic [7:0]        par_acc_q;
  logic [7:0]        par_err_cnt_q;
  logic [7:0]        drop_cnt_q;
  logic              error_q;
  logic              in_suspend_q;
  logic              in_suspend_d;
  logic              router_en_q;
  logic [NUM_CH-1:0] ch_en_q;
  logic [5:0]        max_len_q;
  logic [7:0]        hrdata_q;
  logic [7:0]        rd_data;

  logic [NUM_CH-1:0] push_v, pop_v, full_v, empty_v, near_full_v;
  logic [3:0]        full_ext, pop_ext, near_full_ext, ch_en_ext;

  logic [1:0]        hdr_addr;
  logic [5:0]        hdr_len;
  logic              hdr_ok;
  logic              push_req, push_ok, overflow;
  logic [1:0]        push_ch;

  assign hdr_addr      = bus.in_data[1:0];
  assign hdr_len       = bus.in_data[7:2];
  assign ch_en_ext     = 4'(ch_en_q);
  assign full_ext      = 4'(full_v);
  assign pop_ext       = 4'(pop_v);
  assign near_full_ext = 4'(near_full_v);

  // Routing decision is made only on the header; in-flight packets keep cur_ch_q.
  assign hdr_ok = (int'(hdr_addr) < NUM_CH) && ch_en_ext[hdr_addr] &&
                  (hdr_len != 6'd0) && (hdr_len <= max_len_q);

  always_comb begin
    push_req = 1'b0;
    push_ch  = cur_ch_q;
    if (bus.in_data_vld) begin
      unique case (state_q)
        S_IDLE: begin
          push_req = hdr_ok;
          push_ch  = hdr_addr;
        end
        S_PAYLOAD, S_PARITY: push_req = 1'b1;
        default: ;
      endcase
    end
  end

  // A full FIFO that pops in the same cycle can still take the byte.
  assign overflow = push_req && full_ext[push_ch] && !pop_ext[push_ch];
  assign push_ok  = push_req && !overflow;

  // in_suspend is registered, so it is derived from next-cycle occupancy and
  // leaves room for the byte the source may still send after assertion.
  always_comb begin
    if (!router_en_q)
      in_suspend_d = 1'b1;
    else if (state_q == S_PAYLOAD || state_q == S_PARITY)
      in_suspend_d = near_full_ext[cur_ch_q];
    else
      in_suspend_d = |near_full_v;
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] dout_q;
    logic              vld_q;

    assign push_v[gi]      = push_ok && (push_ch == 2'(gi));
    assign pop_v[gi]       = (count_q != '0) && !bus.suspend_ch[gi];
    assign full_v[gi]      = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty_v[gi]     = (count_q == '0);
    assign near_full_v[gi] = (count_d >= (AW+1)'(FIFO_DEPTH - 2));

    always_comb begin
      count_d = count_q;
      if (push_v[gi] && !pop_v[gi])
        count_d = count_q + 1'b1;
      else if (!push_v[gi] && pop_v[gi])
        count_d = count_q - 1'b1;
    end

    always_ff @(posedge clock) begin
      if (push_v[gi])
        mem_q[wr_ptr_q] <= bus.in_data;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        dout_q   <= '0;
        vld_q    <= 1'b0;
      end else begin
        count_q <= count_d;
        vld_q   <= pop_v[gi];
        if (push_v[gi])
          wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop_v[gi]) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          dout_q   <= mem_q[rd_ptr_q];
        end
      end
    end

    assign bus.data_ch[gi*DATA_W +: DATA_W] = dout_q;
    assign bus.data_vld_ch[gi]              = vld_q;
  end

  // Input FSM with registered error and in_suspend.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      len_cnt_q     <= '0;
      cur_ch_q      <= '0;
      par_acc_q     <= '0;
      par_err_cnt_q <= '0;
      drop_cnt_q    <= '0;
      error_q       <= 1'b0;
      in_suspend_q  <= 1'b0;
    end else begin
      error_q      <= overflow;
      in_suspend_q <= in_suspend_d;
      if (overflow && drop_cnt_q != 8'hFF)
        drop_cnt_q <= drop_cnt_q + 1'b1;
      if (bus.in_data_vld) begin
        unique case (state_q)
          S_IDLE: begin
            len_cnt_q <= hdr_len;
            par_acc_q <= bus.in_data;
            if (hdr_ok) begin
              state_q  <= S_PAYLOAD;
              cur_ch_q <= hdr_addr;
            end else begin
              // Header drop never coincides with overflow (nothing is pushed).
              state_q <= S_DROP;
              if (drop_cnt_q != 8'hFF)
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
          end
          S_PAYLOAD: begin
            par_acc_q <= par_acc_q ^ bus.in_data;
            len_cnt_q <= len_cnt_q - 1'b1;
            if (len_cnt_q == 6'd1)
              state_q <= S_PARITY;
          end
          S_PARITY: begin
            if (bus.in_data != par_acc_q) begin
              error_q <= 1'b1;
              if (par_err_cnt_q != 8'hFF)
                par_err_cnt_q <= par_err_cnt_q + 1'b1;
            end
            state_q <= S_IDLE;
          end
          S_DROP: begin
            // Counter loaded with length, so length+1 bytes are swallowed.
            if (len_cnt_q == 6'd0)
              state_q <= S_IDLE;
            else
              len_cnt_q <= len_cnt_q - 1'b1;
          end
        endcase
      end
    end
  end

`ifdef YAPP_ROUTER_STATS_EN
  logic [NUM_CH*8-1:0] pkt_cnt_flat;
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_stats
    logic [7:0] pkt_cnt_q;
    always_ff @(posedge clock) begin
      if (reset)
        pkt_cnt_q <= '0;
      else if (state_q == S_PARITY && push_v[gi] && pkt_cnt_q != 8'hFF)
        pkt_cnt_q <= pkt_cnt_q + 1'b1;
    end
    assign pkt_cnt_flat[gi*8 +: 8] = pkt_cnt_q;
  end
`endif

  always_comb begin
    rd_data = 8'h00;
    case (bus.haddr)
      16'h1000: rd_data = {7'd0, router_en_q};
      16'h1001: rd_data = 8'(ch_en_q);
      16'h1002: rd_data = {2'd0, max_len_q};
      16'h1003: rd_data = par_err_cnt_q;
      16'h1004: rd_data = drop_cnt_q;
      16'h1005: rd_data = 8'(empty_v);
      default: begin
`ifdef YAPP_ROUTER_STATS_EN
        if (bus.haddr[15:2] == 14'h0404 && int'(bus.haddr[1:0]) < NUM_CH)
          rd_data = pkt_cnt_flat[bus.haddr[1:0]*8 +: 8];
`endif
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      router_en_q <= 1'b1;
      ch_en_q     <= '1;
      max_len_q   <= 6'd63;
      hrdata_q    <= '0;
    end else begin
      hrdata_q <= 8'h00;
      if (bus.hen && bus.hwr_rd) begin
        case (bus.haddr)
          16'h1000: router_en_q <= bus.hwdata[0];
          16'h1001: ch_en_q     <= bus.hwdata[NUM_CH-1:0];
          16'h1002: max_len_q   <= bus.hwdata[5:0];
          default: ;
        endcase
      end else if (bus.hen) begin
        hrdata_q <= rd_data;
      end
    end
  end

  assign bus.in_suspend = in_suspend_q;
  assign bus.error      = error_q;
  assign bus.hrdata     = hrdata_q;
endmodule

// File: tb/tb_yapp_router_nch.sv
// ---------------------------------------------------------------------------
// tb_yapp_router_nch
// Self-checking bench for yapp_router_nch built with NUM_CH = 3.
// Expected output bytes are queued per channel as stimulus is driven and
// compared when the router presents them.
// ---------------------------------------------------------------------------
module tb_yapp_router_nch;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   err_cnt = 0;

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [7:0] exp2[$];
  logic [7:0] pkt[$];

  yapp_router_nch_if #(.NUM_CH(3)) bus ();

  yapp_router_nch #(.NUM_CH(3), .FIFO_DEPTH(16), .DATA_W(8)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void sb_push(input int ch, input logic [7:0] b);
    case (ch)
      0:       exp0.push_back(b);
      1:       exp1.push_back(b);
      default: exp2.push_back(b);
    endcase
  endfunction

  // Output monitor and error pulse counter, sampled on the falling edge.
  always @(negedge clk) begin
    int         have;
    logic [7:0] got_b;
    logic [7:0] exp_b;
    if (bus.error === 1'b1) err_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (bus.data_vld_ch[i] === 1'b1) begin
        got_b = bus.data_ch[i*8 +: 8];
        have  = (i == 0) ? exp0.size() : (i == 1) ? exp1.size() : exp2.size();
        if (have == 0) begin
          check_val($sformatf("out_unexpected_ch%0d", i), 32'(have), 32'd1);
        end else begin
          case (i)
            0:       exp_b = exp0.pop_front();
            1:       exp_b = exp1.pop_front();
            default: exp_b = exp2.pop_front();
          endcase
          $display("out ch%0d byte=%02h", i, got_b);
          check_val($sformatf("out_ch%0d", i), 32'(got_b), 32'(exp_b));
        end
      end
    end
  end

  task automatic hbus_write(input logic [15:0] a, input logic [7:0] d);
    bus.haddr = a; bus.hwdata = d; bus.hwr_rd = 1'b1; bus.hen = 1'b1;
    tick();
    bus.hen = 1'b0; bus.hwr_rd = 1'b0;
    $display("hbus wr %04h <- %02h", a, d);
  endtask

  task automatic check_reg(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus.haddr = a; bus.hwr_rd = 1'b0; bus.hen = 1'b1;
    tick();
    bus.hen = 1'b0;
    d = bus.hrdata;
    $display("hbus rd %04h -> %02h", a, d);
    check_val(tag, 32'(d), 32'(exp));
  endtask

  task automatic build(input logic [1:0] addr, input int len, input bit bad_par);
    logic [7:0] p;
    logic [7:0] b;
    logic [5:0] l6;
    l6 = 6'(len);
    pkt.delete();
    p = {l6, addr};
    pkt.push_back(p);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      pkt.push_back(b);
      p = p ^ b;
    end
    pkt.push_back(bad_par ? ~p : p);
  endtask

  // Sends pkt; the first nfwd bytes are expected on channel ch.
  task automatic send_pkt(input int ch, input int nfwd, input bit exp_err,
                          input bit lat_chk, input bit ign_sus);
    int guard;
    $display("pkt hdr=%02h bytes=%0d ch=%0d fwd=%0d", pkt[0], pkt.size(), ch, nfwd);
    for (int i = 0; i < pkt.size(); i++) begin
      guard = 0;
      while (!ign_sus && bus.in_suspend && guard < 1000) begin
        bus.in_data_vld = 1'b0;
        tick();
        guard++;
      end
      if (guard >= 1000) check_val("in_suspend_timeout", 32'(guard), 32'd0);
      bus.in_data = pkt[i];
      bus.in_data_vld = 1'b1;
      if (i < nfwd) sb_push(ch, pkt[i]);
      tick();
      if (lat_chk) check_val("lat_vld", 32'(bus.data_vld_ch[ch]), 32'(i >= 1));
    end
    bus.in_data_vld = 1'b0;
    check_val("error_after_parity", 32'(bus.error), 32'(exp_err));
    if (lat_chk) begin
      tick();
      check_val("lat_vld_last", 32'(bus.data_vld_ch[ch]), 32'd1);
      tick();
      check_val("lat_vld_end", 32'(bus.data_vld_ch[ch]), 32'd0);
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp0.size() + exp1.size() + exp2.size()) != 0 && g < 500) begin
      tick();
      g++;
    end
    tick(); tick();
    check_val("drain", 32'(exp0.size() + exp1.size() + exp2.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int e0, first, sent, stall;
    rst = 1'b1;
    bus.in_data = '0; bus.in_data_vld = 1'b0; bus.suspend_ch = '0;
    bus.haddr = '0; bus.hwdata = '0; bus.hen = 1'b0; bus.hwr_rd = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_val("rst_in_suspend", 32'(bus.in_suspend), 32'd0);
    check_val("rst_data_vld",   32'(bus.data_vld_ch), 32'd0);
    check_val("rst_data_ch",    32'(bus.data_ch), 32'd0);
    check_val("rst_error",      32'(bus.error), 32'd0);
    check_val("rst_hrdata",     32'(bus.hrdata), 32'd0);
    check_reg("rst_ctrl",   16'h1000, 8'h01);
    check_reg("rst_ch_en",  16'h1001, 8'h07);
    check_reg("rst_maxlen", 16'h1002, 8'd63);
    check_reg("rst_parerr", 16'h1003, 8'h00);
    check_reg("rst_drop",   16'h1004, 8'h00);
    check_reg("rst_empty",  16'h1005, 8'h07);
    tick();
    check_val("hrdata_idle", 32'(bus.hrdata), 32'd0);

    // Good packet to ch1, latency 2 and back-to-back output
    e0 = err_cnt;
    pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    send_pkt(1, 5, 1'b0, 1'b1, 1'b0);
    wait_drain();
    check_val("t1_no_error", 32'(err_cnt - e0), 32'd0);

    // Bad parity: forwarded, one-cycle error pulse
    pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
    send_pkt(1, 5, 1'b1, 1'b0, 1'b0);
    tick();
    check_val("t2_error_one_cycle", 32'(bus.error), 32'd0);
    wait_drain();
    check_reg("t2_parerr", 16'h1003, 8'h01);

    // Drops: addr >= NUM_CH, then disabled channel
    build(2'd3, 3, 1'b0);
    send_pkt(3, 0, 1'b0, 1'b0, 1'b0);
    hbus_write(16'h1001, 8'h05);
    check_reg("t3_ch_en", 16'h1001, 8'h05);
    build(2'd1, 3, 1'b0);
    send_pkt(1, 0, 1'b0, 1'b0, 1'b0);
    wait_drain();
    check_reg("t3_drop", 16'h1004, 8'h02);
    hbus_write(16'h1001, 8'h07);

    // max_len boundary
    hbus_write(16'h1002, 8'h04);
    build(2'd2, 5, 1'b0);
    send_pkt(2, 0, 1'b0, 1'b0, 1'b0);
    build(2'd2, 4, 1'b0);
    send_pkt(2, 6, 1'b0, 1'b0, 1'b0);
    wait_drain();
    check_reg("t4_drop", 16'h1004, 8'h03);
    hbus_write(16'h1002, 8'd63);

    // Zero length: header plus one byte swallowed, next packet routes
    pkt = '{8'h00, 8'hAB};
    send_pkt(0, 0, 1'b0, 1'b0, 1'b0);
    build(2'd0, 2, 1'b0);
    send_pkt(0, 4, 1'b0, 1'b0, 1'b0);
    wait_drain();
    check_reg("t5_drop", 16'h1004, 8'h04);

    // Back-pressure: in_suspend after 14 bytes, release drains in order
    e0 = err_cnt;
    bus.suspend_ch = 3'b001;
    build(2'd0, 20, 1'b0);
    $display("pkt hdr=%02h bytes=%0d ch=0 flow-controlled", pkt[0], pkt.size());
    first = -1; sent = 0; stall = 0;
    for (int g = 0; g < 400 && sent < pkt.size(); g++) begin
      if (bus.in_suspend) begin
        bus.in_data_vld = 1'b0;
        if (first < 0) first = sent;
        stall++;
        if (stall == 5) bus.suspend_ch = 3'b000;
      end else begin
        bus.in_data = pkt[sent];
        bus.in_data_vld = 1'b1;
        sb_push(0, pkt[sent]);
        sent++;
      end
      tick();
    end
    bus.in_data_vld = 1'b0;
    check_val("sus_first_assert", 32'(first), 32'd14);
    check_val("sus_all_sent", 32'(sent), 32'(pkt.size()));
    wait_drain();
    check_val("sus_no_error", 32'(err_cnt - e0), 32'd0);

    // Overflow: source ignores in_suspend, 6 of 22 bytes discarded
    e0 = err_cnt;
    bus.suspend_ch = 3'b001;
    build(2'd0, 20, 1'b0);
    send_pkt(0, 16, 1'b1, 1'b0, 1'b1);
    tick();
    check_val("ovf_error_pulses", 32'(err_cnt - e0), 32'd6);
    check_reg("ovf_drop", 16'h1004, 8'd10);
    bus.suspend_ch = 3'b000;
    wait_drain();

    // Reset in mid-payload discards partial packet
    bus.suspend_ch = 3'b100;
    pkt = '{8'h16, 8'hA1, 8'hA2};
    for (int i = 0; i < 3; i++) begin
      bus.in_data = pkt[i]; bus.in_data_vld = 1'b1;
      tick();
    end
    bus.in_data_vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mid_rst_vld", 32'(bus.data_vld_ch), 32'd0);
    bus.suspend_ch = 3'b000;
    repeat (4) tick();
    check_val("mid_rst_vld_later", 32'(bus.data_vld_ch), 32'd0);
    check_reg("mid_rst_empty", 16'h1005, 8'h07);
    check_reg("mid_rst_drop", 16'h1004, 8'h00);
    build(2'd2, 5, 1'b0);
    send_pkt(2, 7, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // HBUS odds and ends
    hbus_write(16'h1003, 8'h55);
    check_reg("ro_write_ignored", 16'h1003, 8'h00);
    check_reg("unmapped_read", 16'h2000, 8'h00);
    check_reg("stats_ch0", 16'h1010, 8'h00);
    check_reg("stats_missing_ch", 16'h1013, 8'h00);
`ifdef YAPP_ROUTER_STATS_EN
    check_reg("stats_ch2", 16'h1012, 8'h01);
`else
    check_reg("stats_ch2", 16'h1012, 8'h00);
`endif
    hbus_write(16'h1000, 8'h00);
    tick();
    check_val("router_dis_suspend", 32'(bus.in_suspend), 32'd1);
    hbus_write(16'h1000, 8'h01);
    tick();
    check_val("router_en_suspend", 32'(bus.in_suspend), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
